// File: rtl/mul_unit.sv
// Iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Works on operand magnitudes and applies the product sign in the single DONE cycle.
module mul_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             MulE,
    input  logic [1:0]       MulCtrlE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    output logic             Mul,
    output logic             MulDoneE,
    output logic [WIDTH-1:0] MulResultE
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state, state_next;
    logic [CW-1:0]       count;
    logic [WIDTH-1:0]    mcand;
    logic [2*WIDTH:0]    prod;
    logic                neg;
    logic [1:0]          op;

    logic                a_signed, b_signed;
    logic [WIDTH:0]      hi_next;
    logic [2*WIDTH-1:0]  full;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic             is_signed);
        return (is_signed && x[WIDTH-1]) ? -x : x;
    endfunction

    // rs1 is signed for MULH/MULHSU, rs2 only for MULH; MUL runs unsigned.
    assign a_signed = (MulCtrlE == 2'b01) || (MulCtrlE == 2'b10);
    assign b_signed = (MulCtrlE == 2'b01);

    // The upper accumulator carries one extra bit so the add never overflows before the shift.
    assign hi_next = prod[0] ? (prod[2*WIDTH:WIDTH] + {1'b0, mcand}) : prod[2*WIDTH:WIDTH];
    assign full    = neg ? -prod[2*WIDTH-1:0] : prod[2*WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            mcand <= '0;
            prod  <= '0;
            neg   <= 1'b0;
            op    <= 2'b00;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (MulE) begin
                        mcand <= magnitude(SrcAE, a_signed);
                        prod  <= {{(WIDTH+1){1'b0}}, magnitude(SrcBE, b_signed)};
                        neg   <= (a_signed & SrcAE[WIDTH-1]) ^ (b_signed & SrcBE[WIDTH-1]);
                        op    <= MulCtrlE;
                        count <= '0;
                    end
                end
                RUN: begin
                    prod  <= {1'b0, hi_next, prod[WIDTH-1:1]};
                    count <= count + CW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (MulE) state_next = RUN;
            RUN:     if (count == CNT_LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Stall is combinational so the hazard unit holds the pipe in the issue cycle itself.
    always_comb begin
        Mul        = rst_n & (((state == IDLE) & MulE) | (state == RUN));
        MulDoneE   = (state == DONE);
        MulResultE = '0;
        if (state == DONE)
            MulResultE = (op == 2'b00) ? full[WIDTH-1:0] : full[2*WIDTH-1:WIDTH];
    end

endmodule

// File: tb/tb_mul_unit.sv
// Scoreboard bench for mul_unit: expected products are queued at issue and popped at MulDoneE.
module tb_mul_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MulE;
    logic [1:0]  MulCtrlE;
    logic [31:0] SrcAE, SrcBE;
    logic        Mul, MulDoneE;
    logic [31:0] MulResultE;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    mul_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .MulE(MulE), .MulCtrlE(MulCtrlE),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .Mul(Mul), .MulDoneE(MulDoneE),
        .MulResultE(MulResultE)
    );

    always #5 clk = ~clk;

    // Reference: sign/zero-extend to 64 bits and multiply directly.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] ax, bx, p;
        ax = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        bx = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ax * bx;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Called just after a rising edge with the issue inputs already applied.
    task automatic wait_result(output logic [31:0] res, output int busy, output bit ok,
                               output logic mul_at_done, output int leak);
        busy = 0; ok = 0; leak = 0; res = '0; mul_at_done = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (MulDoneE) begin
                res = MulResultE; ok = 1; mul_at_done = Mul;
                break;
            end
            if (MulResultE !== 32'h0) leak++;
            if (Mul) busy++;
            @(posedge clk); #1;
            MulE = 1'b0; SrcAE = $urandom; SrcBE = $urandom;
            MulCtrlE = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic run_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output int busy, output bit ok,
                           output logic mul_at_done, output int leak);
        @(posedge clk); #1;
        MulE = 1'b1; MulCtrlE = op; SrcAE = a; SrcBE = b;
        exp_q.push_back(model(op, a, b));
        wait_result(res, busy, ok, mul_at_done, leak);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; MulE = 1'b1; MulCtrlE = 2'b00; SrcAE = 32'd3; SrcBE = 32'd4;
        #2;
        checks++; if (Mul !== 1'b0) begin errors++; $display("FAIL reset_mul got %b want 0", Mul); end
        checks++; if (MulDoneE !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", MulDoneE); end
        checks++; if (MulResultE !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", MulResultE); end
        repeat (2) @(negedge clk);
        checks++; if (Mul !== 1'b0) begin errors++; $display("FAIL reset_hold_mul got %b want 0", Mul); end
        @(posedge clk); #1;
        MulE = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        checks++; if (Mul !== 1'b0 || MulDoneE !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset got Mul=%b Done=%b want 0 0", Mul, MulDoneE); end
    endtask

    task automatic test_mul_basic;
        logic [31:0] res, expv; int busy, leak; bit ok; logic mad;
        run_mul(2'b00, 32'd7, 32'd6, res, busy, ok, mad, leak);
        expv = exp_q.pop_front();
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got no MulDoneE want done"); end
        checks++; if (busy != 33) begin errors++; $display("FAIL basic_busy got %0d want 33", busy); end
        checks++; if (res !== expv || res !== 32'h2A) begin errors++; $display("FAIL basic_result got %h want %h", res, 32'h2A); end
        checks++; if (mad !== 1'b0) begin errors++; $display("FAIL basic_mul_in_done got %b want 0", mad); end
        checks++; if (leak != 0) begin errors++; $display("FAIL basic_result_leak got %0d want 0", leak); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (MulDoneE !== 1'b0 || Mul !== 1'b0 || MulResultE !== 32'h0) begin
            errors++; $display("FAIL basic_idle got Done=%b Mul=%b Res=%h want 0 0 0", MulDoneE, Mul, MulResultE); end
    endtask

    task automatic test_signed_ops;
        logic [1:0]  ops  [6] = '{2'b01, 2'b01, 2'b11, 2'b00, 2'b10, 2'b00};
        logic [31:0] as   [6] = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFE};
        logic [31:0] bs   [6] = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3, 32'd3};
        logic [31:0] want [6] = '{32'h0, 32'h40000000, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFA};
        logic [31:0] res, expv; int busy, leak; bit ok; logic mad;
        for (int i = 0; i < 6; i++) begin
            run_mul(ops[i], as[i], bs[i], res, busy, ok, mad, leak);
            expv = exp_q.pop_front();
            checks++; if (!ok || res !== expv || res !== want[i]) begin
                errors++; $display("FAIL signed_op%0d got %h want %h", i, res, want[i]); end
        end
    endtask

    task automatic test_random;
        logic [31:0] res, expv, a, b; logic [1:0] op; int busy, leak; bit ok; logic mad;
        for (int i = 0; i < 8; i++) begin
            op = 2'(i % 4);
            a = (i == 4) ? 32'h80000000 : $urandom;
            b = (i == 5) ? 32'h80000000 : $urandom;
            run_mul(op, a, b, res, busy, ok, mad, leak);
            expv = exp_q.pop_front();
            checks++; if (!ok || res !== expv || busy != 33) begin
                errors++; $display("FAIL random%0d op=%0d got %h busy %0d want %h busy 33", i, op, res, busy, expv); end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r1, r2, e1, e2; int b1, b2, l1, l2; bit ok1, ok2; logic m1, m2;
        run_mul(2'b00, 32'd3, 32'd5, r1, b1, ok1, m1, l1);
        run_mul(2'b00, 32'd4, 32'd4, r2, b2, ok2, m2, l2);
        e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
        checks++; if (!ok1 || r1 !== e1 || r1 !== 32'd15) begin errors++; $display("FAIL b2b_first got %h want %h", r1, 32'd15); end
        checks++; if (!ok2 || r2 !== e2 || r2 !== 32'd16) begin errors++; $display("FAIL b2b_second got %h want %h", r2, 32'd16); end
        checks++; if (m1 !== 1'b0 || b2 != 33) begin
            errors++; $display("FAIL b2b_gap got Mul_in_done=%b busy2=%0d want 0 33", m1, b2); end
    endtask

    task automatic test_reset_midrun;
        logic [31:0] res, expv; int busy, leak; bit ok; logic mad;
        @(posedge clk); #1;
        MulE = 1'b1; MulCtrlE = 2'b00; SrcAE = $urandom; SrcBE = $urandom;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            MulE = 1'b0; SrcAE = $urandom; SrcBE = $urandom;
        end
        checks++; if (Mul !== 1'b1) begin errors++; $display("FAIL midrun_busy got %b want 1", Mul); end
        rst_n = 1'b0; MulE = 1'b1; SrcAE = 32'd9; SrcBE = 32'd9;
        #1;
        checks++; if (Mul !== 1'b0 || MulDoneE !== 1'b0 || MulResultE !== 32'h0) begin
            errors++; $display("FAIL midrun_reset got Mul=%b Done=%b Res=%h want 0 0 0", Mul, MulDoneE, MulResultE); end
        @(negedge clk);
        checks++; if (Mul !== 1'b0) begin errors++; $display("FAIL midrun_reset_hold got %b want 0", Mul); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.push_back(model(2'b00, 32'd9, 32'd9));
        wait_result(res, busy, ok, mad, leak);
        expv = exp_q.pop_front();
        checks++; if (!ok || res !== expv || res !== 32'd81) begin errors++; $display("FAIL post_reset_result got %h want %h", res, 32'd81); end
        checks++; if (busy != 33) begin errors++; $display("FAIL post_reset_busy got %0d want 33", busy); end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_signed_ops();
        test_random();
        test_back_to_back();
        test_reset_midrun();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d want 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
